// File: rtl/noc_local_port_arbiter.sv
// Local-port concentrator: per-client tx FIFOs merged round-robin onto the router, rx packets steered by select field.
// Define NOC_PORT_STATS_EN to build the tx_count/rx_count statistics counters; otherwise both read as zero.
module noc_local_port_arbiter #(
    parameter int NUM_SOURCES  = 4,
    parameter int PACKET_WIDTH = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int SINK_SEL_LSB = 22
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_SOURCES*PACKET_WIDTH-1:0] src_packet,
    input  logic [NUM_SOURCES-1:0]              src_valid,
    output logic [NUM_SOURCES-1:0]              src_ready,
    output logic [PACKET_WIDTH-1:0]             tx_packet,
    output logic                                tx_valid,
    input  logic                                tx_ready,
    input  logic [PACKET_WIDTH-1:0]             rx_packet,
    input  logic                                rx_valid,
    output logic                                rx_ready,
    output logic [PACKET_WIDTH-1:0]             sink_packet,
    output logic [NUM_SOURCES-1:0]              sink_valid,
    input  logic [NUM_SOURCES-1:0]              sink_ready,
    output logic                                sel_error,
    output logic [31:0]                         tx_count,
    output logic [31:0]                         rx_count
);

    localparam int SEL_W = $clog2(NUM_SOURCES);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [SEL_W:0]   NSRC_C   = (SEL_W + 1)'(NUM_SOURCES);
    localparam logic [SEL_W-1:0] LAST_SRC = SEL_W'(NUM_SOURCES - 1);

    // Handshake: a transfer happens on the clock edge where valid && ready are both high;
    // a producer that raises valid holds it and its data stable until that edge.

    logic [NUM_SOURCES-1:0]              push;
    logic [NUM_SOURCES-1:0]              pop;
    logic [NUM_SOURCES-1:0]              nonempty;
    logic [NUM_SOURCES*PACKET_WIDTH-1:0] head_flat;

    for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_fifo
        logic [PACKET_WIDTH-1:0] mem_q [FIFO_DEPTH];
        logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
        logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
        logic [CW-1:0]           count_q, count_d;

        // Ready comes from the registered count only, so a full FIFO never takes credit for a same-cycle pop.
        assign src_ready[g] = (count_q != DEPTH_C);
        assign push[g]      = src_valid[g] & src_ready[g];
        assign nonempty[g]  = (count_q != '0);
        assign head_flat[g*PACKET_WIDTH +: PACKET_WIDTH] = mem_q[rd_ptr_q];

        assign wr_ptr_d = push[g] ? wr_ptr_q + AW'(1) : wr_ptr_q;
        assign rd_ptr_d = pop[g]  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        assign count_d  = count_q + CW'(push[g]) - CW'(pop[g]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end

        always_ff @(posedge clk) begin
            if (push[g]) begin
                mem_q[wr_ptr_q] <= src_packet[g*PACKET_WIDTH +: PACKET_WIDTH];
            end
        end
    end

    logic                    tx_valid_q, tx_valid_d;
    logic [PACKET_WIDTH-1:0] tx_packet_q, tx_packet_d;
    logic [SEL_W-1:0]        last_grant_q, last_grant_d;
    logic                    load;
    logic                    found;
    int                      idx;
    int                      gnt_idx;

    always_comb begin
        load         = !tx_valid_q || tx_ready;
        found        = 1'b0;
        idx          = 0;
        gnt_idx      = 0;
        pop          = '0;
        tx_valid_d   = tx_valid_q;
        tx_packet_d  = tx_packet_q;
        last_grant_d = last_grant_q;
        // Cyclic search starting just after the previous winner.
        for (int k = 1; k <= NUM_SOURCES; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_SOURCES;
            if (!found && nonempty[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        if (load) begin
            tx_valid_d = found;
            if (found) begin
                pop[gnt_idx] = 1'b1;
                tx_packet_d  = head_flat[gnt_idx*PACKET_WIDTH +: PACKET_WIDTH];
                last_grant_d = SEL_W'(gnt_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid_q   <= 1'b0;
            tx_packet_q  <= '0;
            last_grant_q <= LAST_SRC;
        end else begin
            tx_valid_q   <= tx_valid_d;
            tx_packet_q  <= tx_packet_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign tx_valid  = tx_valid_q;
    assign tx_packet = tx_packet_q;

    logic                    held_q, held_d;
    logic [PACKET_WIDTH-1:0] held_pkt_q, held_pkt_d;
    logic                    sel_error_q, sel_error_d;
    logic [SEL_W-1:0]        sel;
    logic                    sel_ok;
    logic                    sel_rdy;
    logic                    sink_fire;
    logic                    drop;
    logic                    rx_fire;

    assign sel    = held_pkt_q[SINK_SEL_LSB +: SEL_W];
    assign sel_ok = ({1'b0, sel} < NSRC_C);

    always_comb begin
        sel_rdy    = 1'b0;
        sink_valid = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_rdy       = sink_ready[i];
                sink_valid[i] = held_q && sel_ok;
            end
        end
    end

    // A packet with an out-of-range select is dropped on the edge after capture.
    assign sink_fire = held_q && sel_ok && sel_rdy;
    assign drop      = held_q && !sel_ok;
    assign rx_ready  = !held_q || (sel_ok && sel_rdy);
    assign rx_fire   = rx_valid && rx_ready;

    always_comb begin
        held_d      = held_q;
        held_pkt_d  = held_pkt_q;
        sel_error_d = sel_error_q | drop;
        if (rx_fire) begin
            held_d     = 1'b1;
            held_pkt_d = rx_packet;
        end else if (sink_fire || drop) begin
            held_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q      <= 1'b0;
            held_pkt_q  <= '0;
            sel_error_q <= 1'b0;
        end else begin
            held_q      <= held_d;
            held_pkt_q  <= held_pkt_d;
            sel_error_q <= sel_error_d;
        end
    end

    assign sink_packet = held_q ? held_pkt_q : '0;
    assign sel_error   = sel_error_q;

`ifdef NOC_PORT_STATS_EN
    logic        tx_fire;
    logic [31:0] tx_count_q, tx_count_d;
    logic [31:0] rx_count_q, rx_count_d;

    assign tx_fire    = tx_valid_q && tx_ready;
    assign tx_count_d = tx_fire   ? tx_count_q + 32'd1 : tx_count_q;
    assign rx_count_d = sink_fire ? rx_count_q + 32'd1 : rx_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_count_q <= '0;
            rx_count_q <= '0;
        end else begin
            tx_count_q <= tx_count_d;
            rx_count_q <= rx_count_d;
        end
    end

    assign tx_count = tx_count_q;
    assign rx_count = rx_count_q;
`else
    assign tx_count = 32'h0;
    assign rx_count = 32'h0;
`endif

endmodule
